// File: rtl/lcd_mode_sequencer.sv
// rtl/lcd_mode_sequencer.sv - LCD dot/line timing: LY, STAT mode/coincidence, interrupts and CPU lockouts
module lcd_mode_sequencer #(
    parameter int DOTS_PER_LINE = 456,
    parameter int OAM_DOTS      = 80,
    parameter int XFER_DOTS     = 172,
    parameter int VISIBLE_LINES = 144,
    parameter int TOTAL_LINES   = 154
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       dot_en,
    input  logic       lcd_enable,
    input  logic [7:0] lyc,
    input  logic [3:0] stat_int_en,
    output logic [7:0] ly,
    output logic [8:0] dot,
    output logic [1:0] mode,
    output logic       coincidence,
    output logic       vblank_irq,
    output logic       stat_irq,
    output logic       oam_cpu_lock,
    output logic       vram_cpu_lock,
    output logic       line_start,
    output logic       frame_start
);

    localparam logic [1:0] MODE_HBLANK = 2'd0;
    localparam logic [1:0] MODE_VBLANK = 2'd1;
    localparam logic [1:0] MODE_OAM    = 2'd2;
    localparam logic [1:0] MODE_XFER   = 2'd3;

    localparam logic [8:0] DOT_LAST = 9'(DOTS_PER_LINE - 1);
    localparam logic [8:0] OAM_END  = 9'(OAM_DOTS);
    localparam logic [8:0] XFER_END = 9'(OAM_DOTS + XFER_DOTS);
    localparam logic [7:0] LY_VIS   = 8'(VISIBLE_LINES);
    localparam logic [7:0] LY_LAST  = 8'(TOTAL_LINES - 1);

    logic       running_q, running_d;
    logic [7:0] ly_q, ly_d;
    logic [8:0] dot_q, dot_d;
    logic [1:0] mode_q, mode_d;
    logic       stat_prev_q, stat_prev_d;
    logic       line_start_q, line_start_d;
    logic       frame_start_q, frame_start_d;
    logic       vblank_irq_q, vblank_irq_d;
    logic       stat_line;

    function automatic logic [1:0] mode_for(input logic [7:0] l, input logic [8:0] d);
        if (l >= LY_VIS) return MODE_VBLANK;
        if (d < OAM_END) return MODE_OAM;
        if (d < XFER_END) return MODE_XFER;
        return MODE_HBLANK;
    endfunction

    assign coincidence = running_q & (ly_q == lyc);
    assign stat_line   = running_q & ((stat_int_en[3] & coincidence)
                                    | (stat_int_en[2] & (mode_q == MODE_OAM))
                                    | (stat_int_en[1] & (mode_q == MODE_VBLANK))
                                    | (stat_int_en[0] & (mode_q == MODE_HBLANK)));

    always_comb begin
        running_d     = running_q;
        ly_d          = ly_q;
        dot_d         = dot_q;
        stat_prev_d   = stat_line;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        vblank_irq_d  = 1'b0;

        if (!running_q) begin
            // Power-up of the panel restarts the frame regardless of the dot clock.
            if (lcd_enable) begin
                running_d     = 1'b1;
                ly_d          = 8'd0;
                dot_d         = 9'd0;
                line_start_d  = 1'b1;
                frame_start_d = 1'b1;
            end
        end else if (!lcd_enable) begin
            running_d   = 1'b0;
            ly_d        = 8'd0;
            dot_d       = 9'd0;
            stat_prev_d = 1'b0;
        end else if (dot_en) begin
            if (dot_q == DOT_LAST) begin
                dot_d         = 9'd0;
                ly_d          = (ly_q == LY_LAST) ? 8'd0 : ly_q + 8'd1;
                line_start_d  = (ly_d < LY_VIS);
                frame_start_d = (ly_d == 8'd0);
                vblank_irq_d  = (ly_d == LY_VIS);
            end else begin
                dot_d = dot_q + 9'd1;
            end
        end

        mode_d = running_d ? mode_for(ly_d, dot_d) : MODE_HBLANK;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            running_q     <= 1'b0;
            ly_q          <= 8'd0;
            dot_q         <= 9'd0;
            mode_q        <= MODE_HBLANK;
            stat_prev_q   <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            vblank_irq_q  <= 1'b0;
        end else begin
            running_q     <= running_d;
            ly_q          <= ly_d;
            dot_q         <= dot_d;
            mode_q        <= mode_d;
            stat_prev_q   <= stat_prev_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            vblank_irq_q  <= vblank_irq_d;
        end
    end

    assign ly            = ly_q;
    assign dot           = dot_q;
    assign mode          = mode_q;
    assign vblank_irq    = vblank_irq_q;
    assign stat_irq      = stat_line & ~stat_prev_q;
    assign oam_cpu_lock  = running_q & ((mode_q == MODE_OAM) | (mode_q == MODE_XFER));
    assign vram_cpu_lock = running_q & (mode_q == MODE_XFER);
    assign line_start    = line_start_q;
    assign frame_start   = frame_start_q;

endmodule

// File: tb/tb_lcd_mode_sequencer.sv
// tb/tb_lcd_mode_sequencer.sv - scoreboard bench for lcd_mode_sequencer
module tb_lcd_mode_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       dot_en;
    logic       lcd_enable;
    logic [7:0] lyc;
    logic [3:0] stat_int_en;
    logic [7:0] ly;
    logic [8:0] dot;
    logic [1:0] mode;
    logic       coincidence, vblank_irq, stat_irq, oam_cpu_lock, vram_cpu_lock;
    logic       line_start, frame_start;

    always #5 clk = ~clk;

    lcd_mode_sequencer dut (
        .clk(clk), .reset(reset), .dot_en(dot_en), .lcd_enable(lcd_enable),
        .lyc(lyc), .stat_int_en(stat_int_en), .ly(ly), .dot(dot), .mode(mode),
        .coincidence(coincidence), .vblank_irq(vblank_irq), .stat_irq(stat_irq),
        .oam_cpu_lock(oam_cpu_lock), .vram_cpu_lock(vram_cpu_lock),
        .line_start(line_start), .frame_start(frame_start)
    );

    logic [25:0] dut_vec;
    assign dut_vec = {ly, dot, mode, coincidence, vblank_irq, stat_irq,
                      oam_cpu_lock, vram_cpu_lock, line_start, frame_start};

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h (t=%0t)", tag, got, exp, $time);
            if (errors >= 100) begin
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $finish;
            end
        end
    endtask

    // Reference model: position within the frame, ly/dot derived by division.
    logic m_run = 1'b0;
    int   m_pos = 0;
    logic m_prev = 1'b0, m_ls = 1'b0, m_fs = 1'b0, m_vb = 1'b0;
    logic [25:0] sb_q[$];

    function automatic logic [7:0] m_ly();
        return m_run ? 8'(m_pos / 456) : 8'd0;
    endfunction

    function automatic logic [8:0] m_dot();
        return m_run ? 9'(m_pos % 456) : 9'd0;
    endfunction

    function automatic logic [1:0] m_mode();
        if (!m_run) return 2'd0;
        if (m_pos / 456 >= 144) return 2'd1;
        if (m_pos % 456 < 80) return 2'd2;
        if (m_pos % 456 < 252) return 2'd3;
        return 2'd0;
    endfunction

    function automatic logic m_coinc();
        return m_run && (m_ly() == lyc);
    endfunction

    function automatic logic m_line();
        logic [1:0] md;
        md = m_mode();
        return m_run && ((stat_int_en[3] && m_coinc()) || (stat_int_en[2] && md == 2'd2) ||
                         (stat_int_en[1] && md == 2'd1) || (stat_int_en[0] && md == 2'd0));
    endfunction

    function automatic logic [25:0] m_expect();
        logic [1:0] md;
        md = m_mode();
        return {m_ly(), m_dot(), md, m_coinc(), m_vb, m_line() & ~m_prev,
                m_run && (md == 2'd2 || md == 2'd3), m_run && md == 2'd3, m_ls, m_fs};
    endfunction

    task automatic model_edge();
        logic line_old;
        line_old = m_line();
        m_ls = 1'b0; m_fs = 1'b0; m_vb = 1'b0;
        if (reset) begin
            m_run = 1'b0; m_pos = 0; m_prev = 1'b0;
        end else if (!m_run) begin
            m_prev = line_old;
            if (lcd_enable) begin
                m_run = 1'b1; m_pos = 0; m_ls = 1'b1; m_fs = 1'b1;
            end
        end else if (!lcd_enable) begin
            m_run = 1'b0; m_pos = 0; m_prev = 1'b0;
        end else begin
            m_prev = line_old;
            if (dot_en) begin
                m_pos = (m_pos + 1) % 70224;
                m_ls  = (m_pos % 456 == 0) && (m_pos / 456 < 144);
                m_fs  = (m_pos == 0);
                m_vb  = (m_pos == 65664);
            end
        end
    endtask

    task automatic cycle();
        logic [25:0] exp;
        model_edge();
        sb_q.push_back(m_expect());
        @(posedge clk);
        @(negedge clk);
        exp = sb_q.pop_front();
        check_eq("outs", 32'(dut_vec), 32'(exp));
    endtask

    int m2, m3, m0, oam_n, vram_n, m1_n, vb_n, vb_at, ls1_at, fs_at;
    int st_252, st_d0, st_f0, st_vb, co_n, irq_n, irq_ly, stray, held_bad;
    logic [16:0] prev_pos;

    initial begin
        reset = 1'b1; lcd_enable = 1'b0; dot_en = 1'b0; lyc = 8'd0; stat_int_en = 4'd0;
        repeat (3) cycle();
        check_eq("reset_zero", 32'(dut_vec), 32'd0);
        reset = 1'b0; dot_en = 1'b1;
        repeat (3) cycle();
        check_eq("idle_zero", 32'(dut_vec), 32'd0);

        // Free-running frame with HBlank + OAM STAT sources.
        stat_int_en = 4'b0101; lyc = 8'd200; lcd_enable = 1'b1;
        m2 = 0; m3 = 0; m0 = 0; oam_n = 0; vram_n = 0; m1_n = 0; vb_n = 0; vb_at = -1;
        ls1_at = -1; fs_at = -1; st_252 = 0; st_d0 = 0; st_f0 = 0; st_vb = 0;
        prev_pos = '0;
        for (int n = 0; n < 70234; n++) begin
            cycle();
            if (n == 0) begin
                check_eq("start_mode", 32'(mode), 32'd2);
                check_eq("start_fs", 32'(frame_start & line_start), 32'd1);
            end
            if (n < 456) begin
                if (mode == 2'd2) m2++;
                if (mode == 2'd3) m3++;
                if (mode == 2'd0) m0++;
                if (oam_cpu_lock) oam_n++;
                if (vram_cpu_lock) vram_n++;
            end
            if (line_start && ly == 8'd1 && ls1_at < 0) ls1_at = n;
            if (vblank_irq) begin vb_n++; vb_at = n; end
            if (mode == 2'd1) m1_n++;
            if (frame_start && n > 0) begin
                fs_at = n;
                check_eq("wrap_prev_ly", 32'(prev_pos[16:9]), 32'd153);
            end
            if (stat_irq) begin
                if (ly >= 8'd144) st_vb++;
                else if (dot == 9'd252) st_252++;
                else if (dot == 9'd0 && ly == 8'd0) st_f0++;
                else if (dot == 9'd0) st_d0++;
            end
            prev_pos = {ly, dot};
        end
        check_eq("mode2_clks", m2, 80);
        check_eq("mode3_clks", m3, 172);
        check_eq("mode0_clks", m0, 204);
        check_eq("oam_lock_clks", oam_n, 252);
        check_eq("vram_lock_clks", vram_n, 172);
        check_eq("ly1_at", ls1_at, 456);
        check_eq("vblank_count", vb_n, 1);
        check_eq("vblank_at", vb_at, 65664);
        check_eq("mode1_clks", m1_n, 4560);
        check_eq("frame_wrap_at", fs_at, 70224);
        check_eq("stat_252", st_252, 144);
        check_eq("stat_dot0_blocked", st_d0, 0);
        check_eq("stat_frame0", st_f0, 2);
        check_eq("stat_vblank", st_vb, 0);

        // LYC coincidence, immediate lyc write, then disable at ly=10 dot=100.
        stat_int_en = 4'b1000; lyc = 8'd5;
        co_n = 0; irq_n = 0; irq_ly = -1;
        for (int k = 0; k < 6000 && m_pos != 4660; k++) begin
            cycle();
            if (coincidence && ly == 8'd5) co_n++;
            if (stat_irq) begin
                irq_n++;
                irq_ly = {ly, dot};
            end
            if (m_pos == 3242) begin
                lyc = 8'd7;
                #1;
                check_eq("lyc_write_irq", 32'(stat_irq), 32'(m_line() & ~m_prev));
                check_eq("lyc_write_coinc", 32'(coincidence), 32'd1);
            end
        end
        check_eq("disable_point", m_pos, 4660);
        check_eq("lyc_irq_count", irq_n, 1);
        check_eq("lyc_irq_pos", irq_ly, {8'd5, 9'd0});
        check_eq("coinc_clks", co_n, 456);
        lcd_enable = 1'b0;
        cycle();
        check_eq("disable_zero", 32'(dut_vec), 32'd0);
        cycle();

        // Re-enable with the dot clock at half rate.
        stat_int_en = 4'b0100; lcd_enable = 1'b1;
        m2 = 0; m3 = 0; ls1_at = -1; vb_n = 0; stray = 0; held_bad = 0;
        for (int k = 0; k < 1830; k++) begin
            dot_en = (k > 0) && (k % 2 == 0);
            prev_pos = {ly, dot};
            cycle();
            if (k == 0) begin
                check_eq("reen_mode", 32'(mode), 32'd2);
                check_eq("reen_fs", 32'(frame_start), 32'd1);
            end
            if (k < 912) begin
                if (mode == 2'd2) m2++;
                if (mode == 2'd3) m3++;
            end
            if (line_start && ly == 8'd1 && ls1_at < 0) ls1_at = k;
            if (vblank_irq) vb_n++;
            if (k > 0 && !dot_en) begin
                if (line_start || frame_start || vblank_irq || stat_irq) stray++;
                if ({ly, dot} != prev_pos) held_bad++;
            end
        end
        check_eq("half_mode2", m2, 160);
        check_eq("half_mode3", m3, 344);
        check_eq("half_ly1_at", ls1_at, 912);
        check_eq("reen_no_vblank", vb_n, 0);
        check_eq("half_stray_pulse", stray, 0);
        check_eq("half_hold", held_bad, 0);

        // Mid-frame reset.
        dot_en = 1'b1;
        reset = 1'b1;
        cycle();
        check_eq("reset_mid", 32'(dut_vec), 32'd0);
        reset = 1'b0; lcd_enable = 1'b0;
        cycle();
        check_eq("reset_mid_idle", 32'(dut_vec), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lcd_mode_sequencer.md
Name: lcd_mode_sequencer

Overview:
Dot/line timing controller for the LCD pipeline. It runs the per-line mode sequence: OAM scan (mode 2), then pixel transfer (mode 3), then HBlank (mode 0), with VBlank (mode 1) on lines 144-153. It drives LY, the STAT mode and coincidence fields, and the VBlank and STAT interrupt requests. It also sets the CPU lockout flags that share VRAM and OAM between the CPU and the fetcher/renderer.

Parameters:
DOTS_PER_LINE, 456, dots per scanline (dot counter wraps at DOTS_PER_LINE-1)
OAM_DOTS, 80, length of mode 2 in dots
XFER_DOTS, 172, length of mode 3 in dots (fixed; no sprite/scroll penalty)
VISIBLE_LINES, 144, visible lines; equals LCD_LINES of the video types package
TOTAL_LINES, 154, lines per frame including VBlank

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
dot_en  in  1  dot-clock enable; timing advances one dot per clk with dot_en=1
lcd_enable  in  1  LCDC.LCDEnable
lyc  in  8  LYC compare register
stat_int_en  in  4  {CoincidenceInterrupt, Mode2Interrupt, Mode1Interrupt, Mode0Interrupt} from STAT
ly  out  8  current line (LcdY)
dot  out  9  current dot within line, 0..DOTS_PER_LINE-1
mode  out  2  STAT.Mode encoding: 0 HBlank, 1 VBlank, 2 OAM, 3 transfer
coincidence  out  1  STAT.Coincidence
vblank_irq  out  1  one-clk interrupt request pulse
stat_irq  out  1  one-clk interrupt request pulse
oam_cpu_lock  out  1  CPU OAM access blocked
vram_cpu_lock  out  1  CPU VRAM access blocked
line_start  out  1  one-clk pulse at dot 0 of each visible line
frame_start  out  1  one-clk pulse at ly=0, dot=0

Behaviour:
- Reset (highest priority): running=0, ly=0, dot=0, mode=0, stat_prev=0. All outputs are 0.
- Idle (running=0): counters hold at 0 and mode=0. The first clk with lcd_enable=1 sets running=1, ly=0, dot=0, mode=2 and pulses frame_start and line_start, independent of dot_en.
- Disable: any clk with running=1 and lcd_enable=0 sets running=0, ly=0, dot=0, mode=0. No irq pulses are issued in that clk; stat_prev clears. Mid-frame disable is allowed, with no VBlank-only restriction enforced.
- Advance on clk with running & lcd_enable & dot_en:
  - dot increments.
  - At dot=DOTS_PER_LINE-1, dot becomes 0 and ly increments.
  - At ly=TOTAL_LINES-1 and dot=DOTS_PER_LINE-1, ly wraps to 0.
- dot_en=0: all state holds; pulses are 0.
- mode is a register, updated in the same clk as ly/dot from the new values, so it always matches the ly/dot outputs:
  - ly>=VISIBLE_LINES gives 1.
  - dot<OAM_DOTS gives 2.
  - dot<OAM_DOTS+XFER_DOTS (252) gives 3.
  - otherwise 0.
- line_start: pulses in the clk where dot becomes 0 with new ly<VISIBLE_LINES.
- frame_start: pulses in the clk where (ly,dot) becomes (0,0).
- vblank_irq: pulses in the clk where mode becomes 1 (ly=144, dot=0). Exactly once per frame.
- coincidence = running & (ly==lyc). Combinational from the ly register, so an lyc write takes effect immediately.
- STAT line: stat_line = running & ((en[3]&coincidence) | (en[2]&mode==2) | (en[1]&mode==1) | (en[0]&mode==0)).
  - stat_prev registers stat_line each clk.
  - stat_irq = stat_line & ~stat_prev, a rising edge only.
  - If conditions overlap continuously (e.g. mode 0 into mode 2 with both enabled), the line stays high and there is no second pulse.
  - Changing stat_int_en or lyc may create a rising edge and a pulse.
- Lockout (combinational from the mode register):
  - oam_cpu_lock = running & (mode==2 | mode==3).
  - vram_cpu_lock = running & mode==3.
- Widths: dot compares are 9-bit unsigned; ly is 8-bit unsigned; no signed arithmetic.
- Frame length is 456*154 = 70224 dots.

Test Plan:
- Reset, then lcd_enable=1, dot_en=1: clk0 gives mode=2, ly=0. Mode 2 lasts 80 clks, mode 3 lasts 172, mode 0 lasts 204. ly=1 and line_start arrive exactly 456 clks after start. oam_cpu_lock is high for 252 clks and vram_cpu_lock for 172.
- Free-run 2 frames: vblank_irq pulses at 65664 and 135888 clks after start (once per 70224). ly goes 153→0 with frame_start. mode=1 for 4560 clks per frame.
- lyc=5, stat_int_en=4'b1000: single stat_irq at the clk ly becomes 5 (2280 clks). coincidence is high for 456 clks. Writing lyc=ly mid-line gives an immediate single pulse.
- stat_int_en=4'b0101: a pulse at dot 252 of every visible line. There is no pulse at dot 0 of lines 1-143 (blocking). There is a pulse at ly=0 dot 0 after VBlank. There are no pulses during lines 144-153.
- dot_en asserted every 2nd clk: all mode durations double in clks. The state held on dot_en=0 clks is verified, and pulses fire only on advancing clks.
- lcd_enable dropped at ly=10, dot=100: the next clk gives ly=0, dot=0, mode=0, locks 0, no irq. Re-enable gives mode=2 plus frame_start, and no stray vblank_irq. Reset asserted mid-frame likewise clears everything in one clk.
